// File: rtl/conv_bus_pkg.sv
// Shared definitions for the convolution layer DDR3 read and write bridges.
package conv_bus_pkg;

  localparam int CHANNEL_SIZE = 64;
  localparam int BURST_LEN    = 16;
  localparam int REPEAT_TIME  = CHANNEL_SIZE / BURST_LEN;
  localparam int WIDTH        = 32;
  localparam int ADDR_W       = 28;
  localparam int BC_W         = 2;
  localparam int WC_W         = 4;
  localparam int BEAT_SHIFT   = 6;

  localparam logic [3:0] AWLEN_16  = 4'hF;
  localparam logic [3:0] RD_ID     = 4'h1;
  localparam logic [3:0] WR_ID     = 4'h2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    CW_IDLE = 2'd0,
    CW_ADDR = 2'd1,
    CW_DATA = 2'd2,
    CW_RESP = 2'd3
  } cw_state_e;

  // Each burst moves BURST_LEN*WIDTH/8 = 64 bytes; the sum wraps at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [BC_W-1:0]   bc);
    burst_addr = base + {{(ADDR_W-BC_W-BEAT_SHIFT){1'b0}}, bc, {BEAT_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/conv_wr_serializer.sv
// Pixel buffer plus burst/beat counters; presents the current beat word and burst address.
module conv_wr_serializer
  import conv_bus_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [CHANNEL_SIZE*WIDTH-1:0]  pixel,
  input  logic [ADDR_W-1:0]              base,
  input  logic                           beat,
  input  logic                           next_burst,
  output logic [WIDTH-1:0]               word,
  output logic [ADDR_W-1:0]              addr,
  output logic                           last_beat,
  output logic                           last_burst
);

  logic [WIDTH-1:0]  pix_r [CHANNEL_SIZE];
  logic [ADDR_W-1:0] base_r;
  logic [BC_W-1:0]   bc_r;
  logic [WC_W-1:0]   wc_r;

  // Capture the pixel on accept, then step beat and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNEL_SIZE; i++) pix_r[i] <= {WIDTH{1'b0}};
      base_r <= {ADDR_W{1'b0}};
      bc_r   <= {BC_W{1'b0}};
      wc_r   <= {WC_W{1'b0}};
    end else if (load) begin
      for (int i = 0; i < CHANNEL_SIZE; i++) pix_r[i] <= pixel[i*WIDTH +: WIDTH];
      base_r <= base;
      bc_r   <= {BC_W{1'b0}};
      wc_r   <= {WC_W{1'b0}};
    end else begin
      if (beat) begin
        if (last_beat) wc_r <= {WC_W{1'b0}};
        else           wc_r <= wc_r + WC_W'(1);
      end
      if (next_burst) bc_r <= bc_r + BC_W'(1);
    end
  end

  // Channel index is simply {bc, wc} since bursts are BURST_LEN channels long.
  always_comb begin
    word       = pix_r[{bc_r, wc_r}];
    addr       = burst_addr(base_r, bc_r);
    last_beat  = (wc_r == WC_W'(BURST_LEN - 1));
    last_burst = (bc_r == BC_W'(REPEAT_TIME - 1));
  end

endmodule

// File: rtl/conv_wr_bridge.sv
// Writes one conv result pixel to DDR3 as REPEAT_TIME 16-beat bursts and reports done/err.
module conv_wr_bridge
  import conv_bus_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ClCwb_valid,
  input  logic [CHANNEL_SIZE*32-1:0]    ClCwb_result,
  input  logic [27:0]                   ClCwb_addr,
  output logic                          CwbCl_ready,
  output logic                          CwbBus_awvalid,
  input  logic                          BusCwb_awready,
  output logic [27:0]                   CwbBus_awaddr,
  output logic [3:0]                    CwbBus_awlen,
  output logic [3:0]                    CwbBus_awusrid,
  output logic                          CwbBus_wvalid,
  input  logic                          BusCwb_wready,
  output logic [31:0]                   CwbBus_wdata,
  output logic                          CwbBus_wlast,
  input  logic                          BusCwb_bvalid,
  input  logic [3:0]                    BusCwb_bid,
  input  logic [1:0]                    BusCwb_bresp,
  output logic                          CwbBus_bready,
  output logic                          CwbCc_done,
  output logic                          CwbCc_err
);

  cw_state_e         state_r;
  logic              done_r;
  logic              err_r;
  logic              load_s;
  logic              beat_s;
  logic              next_burst_s;
  logic              last_beat_s;
  logic              last_burst_s;
  logic              resp_bad_s;
  logic [WIDTH-1:0]  word_s;
  logic [ADDR_W-1:0] addr_s;

  assign load_s       = (state_r == CW_IDLE) && ClCwb_valid;
  assign beat_s       = (state_r == CW_DATA) && BusCwb_wready;
  assign next_burst_s = (state_r == CW_RESP) && BusCwb_bvalid && !last_burst_s;
  assign resp_bad_s   = (BusCwb_bresp != RESP_OKAY) || (BusCwb_bid != WR_ID);

  conv_wr_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .pixel      (ClCwb_result),
    .base       (ClCwb_addr),
    .beat       (beat_s),
    .next_burst (next_burst_s),
    .word       (word_s),
    .addr       (addr_s),
    .last_beat  (last_beat_s),
    .last_burst (last_burst_s)
  );

  // Burst sequencer with registered done pulse and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CW_IDLE;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        CW_IDLE: if (ClCwb_valid) state_r <= CW_ADDR;
        CW_ADDR: if (BusCwb_awready) state_r <= CW_DATA;
        CW_DATA: if (BusCwb_wready && last_beat_s) state_r <= CW_RESP;
        CW_RESP: begin
          if (BusCwb_bvalid) begin
            // A bad response is recorded but the remaining bursts still go out.
            if (resp_bad_s) err_r <= 1'b1;
            if (last_burst_s) begin
              done_r  <= 1'b1;
              state_r <= CW_IDLE;
            end else begin
              state_r <= CW_ADDR;
            end
          end
        end
        default: state_r <= CW_IDLE;
      endcase
    end
  end

  // Bus outputs decode the registered state; address and data read as zero outside their phase.
  always_comb begin
    CwbCl_ready    = (state_r == CW_IDLE);
    CwbBus_awvalid = (state_r == CW_ADDR);
    CwbBus_wvalid  = (state_r == CW_DATA);
    CwbBus_bready  = (state_r == CW_RESP);
    CwbBus_awlen   = AWLEN_16;
    CwbBus_awusrid = WR_ID;
    CwbBus_wlast   = (state_r == CW_DATA) && last_beat_s;
    CwbCc_done     = done_r;
    CwbCc_err      = err_r;
    if (state_r == CW_ADDR) CwbBus_awaddr = addr_s;
    else                    CwbBus_awaddr = {ADDR_W{1'b0}};
    if (state_r == CW_DATA) CwbBus_wdata = word_s;
    else                    CwbBus_wdata = {WIDTH{1'b0}};
  end

endmodule

// File: tb/tb_conv_wr_bridge.sv
// Scoreboard bench for conv_wr_bridge: a bus model checks every burst address and beat in order.
`timescale 1ns/1ps
module tb_conv_wr_bridge;
  import conv_bus_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       ClCwb_valid = 1'b0;
  logic [CHANNEL_SIZE*32-1:0] ClCwb_result = '0;
  logic [27:0]                ClCwb_addr = 28'h0;
  logic                       CwbCl_ready;
  logic                       CwbBus_awvalid;
  logic                       BusCwb_awready = 1'b0;
  logic [27:0]                CwbBus_awaddr;
  logic [3:0]                 CwbBus_awlen;
  logic [3:0]                 CwbBus_awusrid;
  logic                       CwbBus_wvalid;
  logic                       BusCwb_wready = 1'b0;
  logic [31:0]                CwbBus_wdata;
  logic                       CwbBus_wlast;
  logic                       BusCwb_bvalid = 1'b0;
  logic [3:0]                 BusCwb_bid = 4'h0;
  logic [1:0]                 BusCwb_bresp = 2'b00;
  logic                       CwbBus_bready;
  logic                       CwbCc_done;
  logic                       CwbCc_err;

  conv_wr_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .ClCwb_valid(ClCwb_valid), .ClCwb_result(ClCwb_result), .ClCwb_addr(ClCwb_addr),
    .CwbCl_ready(CwbCl_ready),
    .CwbBus_awvalid(CwbBus_awvalid), .BusCwb_awready(BusCwb_awready),
    .CwbBus_awaddr(CwbBus_awaddr), .CwbBus_awlen(CwbBus_awlen), .CwbBus_awusrid(CwbBus_awusrid),
    .CwbBus_wvalid(CwbBus_wvalid), .BusCwb_wready(BusCwb_wready),
    .CwbBus_wdata(CwbBus_wdata), .CwbBus_wlast(CwbBus_wlast),
    .BusCwb_bvalid(BusCwb_bvalid), .BusCwb_bid(BusCwb_bid), .BusCwb_bresp(BusCwb_bresp),
    .CwbBus_bready(CwbBus_bready),
    .CwbCc_done(CwbCc_done), .CwbCc_err(CwbCc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [27:0] aw_q[$];
  logic [32:0] w_q[$];

  int done_cnt = 0;
  int done_cyc = 0;
  int first_aw_cyc = 0;
  int aw_hs = 0;
  int w_beats = 0;
  int burst_idx = 0;
  int err_burst = -1;
  int bad_id_burst = -1;
  bit stall_en = 1'b0;
  int acc_cyc = 0;

  logic        aw_stall = 1'b0;
  logic        aw_busy = 1'b0;
  logic        w_stall = 1'b0;
  logic [27:0] aw_prev = 28'h0;
  logic [32:0] w_prev = 33'h0;
  logic [27:0] ea;
  logic [32:0] ew;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus model: drives ready/response inputs at negedge and scores every handshake.
  initial begin : bus_model
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_stall = 1'b0; aw_busy = 1'b0; w_stall = 1'b0;
        burst_idx = 0; aw_hs = 0;
        BusCwb_awready = 1'b0; BusCwb_wready = 1'b0;
        BusCwb_bvalid = 1'b0; BusCwb_bresp = 2'b00; BusCwb_bid = 4'h0;
      end else begin
        if (CwbCc_done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("ready_in_done", 64'(CwbCl_ready), 64'd1);
        end
        if (aw_stall) chk("aw_hold", 64'(CwbBus_awaddr), 64'(aw_prev));
        if (CwbBus_awvalid && !aw_busy && (aw_hs % 4 == 0)) first_aw_cyc = cyc;
        BusCwb_awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
        if (CwbBus_awvalid && BusCwb_awready) begin
          aw_hs++;
          if (aw_q.size() == 0) chk("aw_extra", 64'd1, 64'd0);
          else begin
            ea = aw_q.pop_front();
            chk("awaddr", 64'(CwbBus_awaddr), 64'(ea));
            chk("awlen", 64'(CwbBus_awlen), 64'hF);
            chk("awid", 64'(CwbBus_awusrid), 64'h2);
          end
        end
        aw_stall = CwbBus_awvalid && !BusCwb_awready;
        aw_busy  = CwbBus_awvalid;
        aw_prev  = CwbBus_awaddr;

        if (w_stall) chk("w_hold", 64'({CwbBus_wlast, CwbBus_wdata}), 64'(w_prev));
        BusCwb_wready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (CwbBus_wvalid && BusCwb_wready) begin
          w_beats++;
          if (w_q.size() == 0) chk("w_extra", 64'd1, 64'd0);
          else begin
            ew = w_q.pop_front();
            chk("wbeat", 64'({CwbBus_wlast, CwbBus_wdata}), 64'(ew));
          end
        end
        w_stall = CwbBus_wvalid && !BusCwb_wready;
        w_prev  = {CwbBus_wlast, CwbBus_wdata};

        if (CwbBus_bready && (stall_en ? ($urandom_range(0, 2) == 0) : 1'b1)) begin
          BusCwb_bvalid = 1'b1;
          BusCwb_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
          BusCwb_bid    = (burst_idx == bad_id_burst) ? 4'h1 : 4'h2;
          burst_idx     = (burst_idx + 1) % 4;
        end else begin
          BusCwb_bvalid = 1'b0;
          BusCwb_bresp  = 2'b00;
          BusCwb_bid    = 4'h0;
        end
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_ready", 64'(CwbCl_ready), 64'd1);
    chk("rst_awvalid", 64'(CwbBus_awvalid), 64'd0);
    chk("rst_wvalid", 64'(CwbBus_wvalid), 64'd0);
    chk("rst_wlast", 64'(CwbBus_wlast), 64'd0);
    chk("rst_bready", 64'(CwbBus_bready), 64'd0);
    chk("rst_done", 64'(CwbCc_done), 64'd0);
    chk("rst_err", 64'(CwbCc_err), 64'd0);
    chk("rst_awaddr", 64'(CwbBus_awaddr), 64'd0);
    chk("rst_wdata", 64'(CwbBus_wdata), 64'd0);
  endtask

  // Loads the pixel, pushes its expected bursts, raises valid and waits for ready.
  task automatic drive_pixel(input logic [27:0] base, input logic [31:0] pat, input bit rnd);
    logic [31:0] wd;
    int n;
    for (int k = 0; k < CHANNEL_SIZE; k++) begin
      wd = rnd ? $urandom : (pat + 32'(k));
      ClCwb_result[k*32 +: 32] = wd;
      w_q.push_back({(k % 16) == 15, wd});
    end
    for (int b = 0; b < 4; b++) aw_q.push_back(base + 28'(b * 64));
    ClCwb_addr  = base;
    ClCwb_valid = 1'b1;
    n = 0;
    while (!CwbCl_ready && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("accept_wait", 64'(CwbCl_ready), 64'd1);
    acc_cyc = cyc;
  endtask

  task automatic release_pixel();
    @(negedge clk); #1;
    ClCwb_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_wait", 64'(done_cnt - start), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : main
    int d0;
    int b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single pixel, bus always ready: latency and 72-cycle pixel time.
    drive_pixel(28'h0100000, 32'hA000_0000, 1'b0);
    release_pixel();
    wait_done(200);
    chk("aw_latency", 64'(first_aw_cyc - acc_cyc), 64'd1);
    chk("pixel_cycles", 64'(done_cyc - first_aw_cyc), 64'd72);
    chk("t1_aw_left", 64'(aw_q.size()), 64'd0);
    chk("t1_w_left", 64'(w_q.size()), 64'd0);
    chk("t1_err", 64'(CwbCc_err), 64'd0);
    idle(3);

    // Random stalls on every channel.
    stall_en = 1'b1;
    d0 = done_cnt;
    drive_pixel(28'h0234560, 32'h0, 1'b1);
    release_pixel();
    wait_done(3000);
    idle(20);
    chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t2_aw_left", 64'(aw_q.size()), 64'd0);
    chk("t2_w_left", 64'(w_q.size()), 64'd0);
    chk("t2_err", 64'(CwbCc_err), 64'd0);
    stall_en = 1'b0;

    // SLVERR on the second burst: flag is sticky, pixel still completes.
    err_burst = 1;
    drive_pixel(28'h0400400, 32'hC000_0000, 1'b0);
    release_pixel();
    wait_done(200);
    chk("t3_err", 64'(CwbCc_err), 64'd1);
    chk("t3_aw_left", 64'(aw_q.size()), 64'd0);
    chk("t3_w_left", 64'(w_q.size()), 64'd0);
    err_burst = -1;
    idle(10);
    chk("t3_err_sticky", 64'(CwbCc_err), 64'd1);

    // Address wrap, then a second pixel held valid and taken in the done cycle.
    drive_pixel(28'hFFFFFC0, 32'h5000_0000, 1'b0);
    release_pixel();
    d0 = done_cnt;
    drive_pixel(28'h0000100, 32'h6000_0000, 1'b0);
    chk("b2b_in_done", 64'(CwbCc_done), 64'd1);
    chk("b2b_done_cnt", 64'(done_cnt - d0), 64'd1);
    release_pixel();
    chk("b2b_next_addr", 64'(CwbBus_awvalid), 64'd1);
    wait_done(200);
    chk("t5_aw_left", 64'(aw_q.size()), 64'd0);
    chk("t5_w_left", 64'(w_q.size()), 64'd0);
    idle(3);

    // Asynchronous reset in the middle of the first burst's data.
    b0 = w_beats;
    drive_pixel(28'h0300000, 32'h7000_0000, 1'b0);
    release_pixel();
    d0 = 0;
    while ((w_beats - b0) < 7 && d0 < 200) begin
      @(negedge clk); #1;
      d0++;
    end
    chk("t6_reach_beat7", 64'(w_beats - b0), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    aw_q.delete();
    w_q.delete();
    b0 = w_beats;
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    chk("t6_no_beats", 64'(w_beats - b0), 64'd0);
    chk("t6_idle_aw", 64'(CwbBus_awvalid), 64'd0);
    chk("t6_ready", 64'(CwbCl_ready), 64'd1);

    // Fresh pixel after reset, first response carries the wrong ID.
    bad_id_burst = 0;
    drive_pixel(28'h0500000, 32'h8000_0000, 1'b0);
    release_pixel();
    wait_done(200);
    chk("t7_err", 64'(CwbCc_err), 64'd1);
    chk("t7_aw_left", 64'(aw_q.size()), 64'd0);
    chk("t7_w_left", 64'(w_q.size()), 64'd0);
    bad_id_burst = -1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_wr_bridge.md
# conv_wr_bridge

Write-back bridge downstream of the convolution layer. Accepts one result pixel (all output channels, 32-bit each), split into `repeat_time` fixed 16-beat write bursts. Issues the bursts on the DDR3 write bus (address, data and response channels) and reports completion or error to the conv controller. It is the write-side mirror of the pixel read path.

## Interface
- `channel_size`, 64, output channels per pixel
- `repeat_time`, 4, bursts per pixel (`channel_size/16`)
- `burst_len`, 16, beats per burst
- `width`, 32, bus data width in bits
- `wr_id`, 4'h2, AXI ID driven on `awuser_id`

- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `ClCwb_valid`  in  1  result pixel valid
- `ClCwb_result`  in  `channel_size*32`  pixel data; channel 0 in bits [31:0]
- `ClCwb_addr`  in  28  byte address of channel 0
- `CwbCl_ready`  out  1  bridge idle, can accept a pixel
- `CwbBus_awvalid`  out  1  write address valid
- `BusCwb_awready`  in  1  write address accepted
- `CwbBus_awaddr`  out  28  burst start address
- `CwbBus_awlen`  out  4  burst length minus 1, constant 4'hF
- `CwbBus_awusrid`  out  4  burst ID, constant `wr_id`
- `CwbBus_wvalid`  out  1  write data valid
- `BusCwb_wready`  in  1  write beat accepted
- `CwbBus_wdata`  out  32  beat data
- `CwbBus_wlast`  out  1  final beat of burst
- `BusCwb_bvalid`  in  1  write response valid
- `BusCwb_bid`  in  4  response ID
- `BusCwb_bresp`  in  2  response code; 2'b00 is OKAY
- `CwbBus_bready`  out  1  response accepted
- `CwbCc_done`  out  1  one-cycle pulse when a pixel is fully written
- `CwbCc_err`  out  1  sticky error flag; cleared only by reset

## Operation
- **States:** IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - `CwbCl_ready=1`.
  - On `ClCwb_valid`: latch `ClCwb_result` into the pixel buffer, latch base address, clear burst counter `bc` and beat counter `wc`, go to ADDR.
- **ADDR:**
  - `awvalid=1`, `awaddr = base + bc*burst_len*(width/8)`, truncated to 28 bits (wraps modulo 2^28).
  - On `awready` go to DATA.
- **DATA:**
  - `wvalid=1`; `wdata` = channel `bc*burst_len + wc`.
  - `wlast` = (`wc == burst_len-1`).
  - Each `wvalid && wready` increments `wc`. On the `wlast` handshake, clear `wc` and go to RESP.
  - `wready` low holds `wdata`/`wlast` stable.
- **RESP:**
  - `bready=1`.
  - On `bvalid`: set `CwbCc_err` if `bresp != 0` or `bid != wr_id`. Errors do not abort the pixel.
  - Then, if `bc == repeat_time-1`: pulse `CwbCc_done` and go to IDLE. Otherwise increment `bc` and go to ADDR.
- `ClCwb_valid` outside IDLE is ignored. The conv layer must hold `valid` until it sees `ready`.
- **Reset (asserted at any time, including mid-burst):**
  - FSM returns to IDLE; partial pixel is discarded.
  - `CwbCl_ready=1`; all bus valids, `bready`, `wlast`, `done`, `err` = 0; `awaddr`/`wdata` = 0.
- `awaddr`, `awlen` and `awusrid` are held stable while `awvalid` is high.

## Timing
- `CwbCl_ready` is a combinational decode of `state==IDLE`. All other outputs are registered or are decodes of registered state.
- **Accept to first address:** accept at cycle 0 -> `awvalid` high in cycle 1.
- **Address to data:** `awready` handshake at cycle n -> `wvalid` in cycle n+1. Zero-wait beats stream at one per cycle.
- **Data to response:** `wlast` handshake at cycle m -> `bready` in m+1.
- **Best case per pixel:** one address, 16 data and one response cycle per burst, i.e. 18 cycles per burst, 72 cycles total. `done` is asserted in the cycle after the final `bvalid`. `ready` returns in that same cycle.
- A back-to-back pixel accepted on that cycle starts ADDR on the next cycle.

## Structure
- **Package `conv_bus_pkg`:**
  - state enum (`CW_IDLE`, `CW_ADDR`, `CW_DATA`, `CW_RESP`)
  - `BURST_LEN`, `AWLEN_16 = 4'hF`
  - bus ID constants (read ID, `wr_id`)
  - `RESP_OKAY`
  - shared with the read path.
- **Sub-module `conv_wr_serializer`:**
  - holds the pixel buffer and the `bc`/`wc` counters;
  - outputs the current word and last flags;
  - the FSM sits in `conv_wr_bridge`.

## Test plan
- **Single pixel, bus always ready:** channel k = 32'hA000_0000+k, addr 28'h0100000.
  - AW addresses 0x0100000, 0x0100040, 0x0100080, 0x01000C0.
  - 64 beats in channel order; `wlast` on beats 15/31/47/63.
  - `done` at cycle 72.
- **Random `awready`/`wready`/`bvalid` stalls:** `wdata`/`awaddr` stay stable while stalled; identical data sequence; `done` exactly once.
- **Error response:** `bresp=2'b10` on burst 2.
  - `err` rises and stays high; bursts 3 and 4 still issued; `done` still pulses.
- **ID mismatch:** `bid=4'h1` -> `err` set.
- **Address wrap and back-to-back pixels:**
  - addr 28'hFFFFFC0 -> second burst at 28'h0000000.
  - second pixel held valid during the first is accepted in the `done` cycle.
- **Reset mid-DATA (beat 7, burst 1):**
  - all outputs return to reset values asynchronously; `ready=1`.
  - no further beats; next pixel starts from burst 0.
